thumb_decode_stage: RTL and testbench
=====================================

# thumb_decode_stage

Registered Thumb decode stage that replaces the purely combinational decoder in the fetch→execute path. It accepts a stream of instruction halfwords through a valid/ready handshake, buffers them in a parametrised halfword queue, and assembles 32-bit encodings from two halfwords. It fully decodes the shift/add/sub/move/compare group into cmd/register/immediate fields and presents one decoded instruction per handshake to execute, with pipeline flush support for branches.

## Interface
- `QDEPTH`, default 4: halfword queue depth; power of two, ≥2.
- `CMD_W`, default 7: width of `dec_cmd`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: discard all buffered and decoded state.
- `hw_valid` in 1: halfword offered.
- `hw_data` in 16: instruction halfword, program order.
- `hw_ready` out 1: queue can accept a halfword.
- `dec_valid` out 1: decoded instruction valid.
- `dec_ready` in 1: execute accepts the decoded instruction.
- `dec_cmd` out CMD_W: command code.
- `dec_rm`, `dec_rn`, `dec_rd` out 4 each: register fields, zero-extended.
- `dec_imm` out 32: immediate, zero-extended.
- `dec_is32` out 1: instruction is a 32-bit encoding.
- `dec_raw` out 32: raw instruction; `{16'h0, hw}` or `{hw_first, hw_second}`.

## Operation
- Command codes: LSL_imm=0, LSR_imm=1, ASR_imm=2, ADD_reg=3, SUB_reg=4, ADD_imm3=5, SUB_imm3=6, MOV_imm=7, CMP_imm=8, ADD_imm8=9, SUB_imm8=10, CMD_T32=126, CMD_UNDEF=127.
- 32-bit prefix: head `[15:11]` ∈ {11101, 11110, 11111}.
  - Consumes two halfwords.
  - `cmd=CMD_T32`, `dec_is32=1`, register fields and imm = 0.
- 16-bit, `[15:14]=00` group; unused fields are 0.
  - LSL/LSR/ASR (`[13:11]`=000/001/010): imm=`[10:6]`, Rm=`[5:3]`, Rd=`[2:0]`.
    - For LSR/ASR, imm5=0 decodes as imm=32.
  - ADD_reg/SUB_reg (`[13:9]`=01100/01101): Rm=`[8:6]`, Rn=`[5:3]`, Rd=`[2:0]`.
  - ADD_imm3/SUB_imm3 (01110/01111): imm=`[8:6]`, Rn=`[5:3]`, Rd=`[2:0]`.
  - MOV_imm (`[13:11]`=100): Rd=`[10:8]`, imm=`[7:0]`.
  - CMP_imm (101): Rn=`[10:8]`, imm=`[7:0]`.
  - ADD_imm8/SUB_imm8 (110/111): Rd=Rn=`[10:8]`, imm=`[7:0]`.
- Any other 16-bit encoding: `CMD_UNDEF`, fields 0, `dec_raw` valid, `dec_is32=0`.
- Decode-ready condition:
  - Head is 16-bit and count≥1, or
  - Head is a prefix and count≥2.
  - A prefix with count=1 waits; no output, no pop.
- Output register loads when it is decode-ready and (`!dec_valid` or `dec_ready`). The same edge pops 1 or 2 entries.
- Push when `hw_valid && hw_ready`. `hw_ready = (count < QDEPTH)`, based on the current count only.
  - A same-cycle pop does not free space.
- Pointers wrap modulo QDEPTH. Push and pop on the same edge update count by +1−n.
- Flush takes priority over everything. At the next edge:
  - count=0 and pointers=0.
  - `dec_valid=0`.
  - A halfword offered that cycle is dropped.
  - A half-assembled 32-bit pair is lost.
- Reset values:
  - `dec_valid=0`, `dec_cmd=CMD_UNDEF`.
  - `dec_rm`/`dec_rn`/`dec_rd`/`dec_imm`/`dec_raw`/`dec_is32` = 0.
  - Queue empty, so `hw_ready=1` (also while in reset).

## Timing
- Halfword accepted at edge N is in the queue after N. A 16-bit instruction appears with `dec_valid` after edge N+1, giving a 2-cycle latency.
- 32-bit: `dec_valid` follows the edge after the second halfword is enqueued.
- Throughput: one instruction per cycle while `dec_ready=1` and the queue is fed.
- While `dec_valid && !dec_ready`, all `dec_*` outputs hold stable.
- `rst_n` asserted mid-operation clears all state asynchronously. The first push is allowed at the first edge after deassertion.

## Structure
- Package `thumb_pkg`:
  - cmd localparams (including CMD_T32, CMD_UNDEF).
  - Decoded-instruction struct.
  - Function `is_t32_prefix(hw)`.
- Sub-module `hw_queue`: halfword FIFO with push 0/1, pop 0/1/2, head/head+1 peek, count.
- Decode logic is a combinational function of the two peeked halfwords feeding the output register.

## Test plan
- Reset: hold `rst_n` low → `dec_valid=0`, `dec_cmd=127`, `hw_ready=1`. After release, push 16'h2105 → two edges later `dec_cmd=7`, `rd=1`, `imm=5`.
- Push 16'h180A → `cmd=3`, `rm=0`, `rn=1`, `rd=2`, `imm=0`. Push 16'h0808 → `cmd=1`, `imm=32`, `rm=1`, `rd=0`.
- Push 16'hF000, idle 3 cycles, push 16'hF800 → no `dec_valid` until after the second push, then `cmd=126`, `raw=32'hF000F800`, `is32=1`.
- Hold `dec_ready=0`, push 6×16'h2105 → one loads output, QDEPTH enter queue, then `hw_ready=0`. Release `dec_ready` → 5 MOVs in order, one per cycle, outputs stable while stalled.
- Push 16'hF000, assert `flush` one cycle, push 16'h2105 → single MOV output, no T32, `dec_valid` deasserted by flush.
- Push 16'hBF00 → `cmd=127`, `raw=32'h0000BF00`; next instruction decodes normally.

Source files
------------

// File: rtl/thumb_pkg.sv
// rtl/thumb_pkg.sv - Thumb command codes, decoded-instruction record and decode helpers
package thumb_pkg;

  localparam logic [6:0] CMD_LSL_IMM  = 7'd0;
  localparam logic [6:0] CMD_LSR_IMM  = 7'd1;
  localparam logic [6:0] CMD_ASR_IMM  = 7'd2;
  localparam logic [6:0] CMD_ADD_REG  = 7'd3;
  localparam logic [6:0] CMD_SUB_REG  = 7'd4;
  localparam logic [6:0] CMD_ADD_IMM3 = 7'd5;
  localparam logic [6:0] CMD_SUB_IMM3 = 7'd6;
  localparam logic [6:0] CMD_MOV_IMM  = 7'd7;
  localparam logic [6:0] CMD_CMP_IMM  = 7'd8;
  localparam logic [6:0] CMD_ADD_IMM8 = 7'd9;
  localparam logic [6:0] CMD_SUB_IMM8 = 7'd10;
  localparam logic [6:0] CMD_T32      = 7'd126;
  localparam logic [6:0] CMD_UNDEF    = 7'd127;

  typedef struct packed {
    logic [6:0]  cmd;
    logic [3:0]  rm;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [31:0] imm;
    logic        is32;
    logic [31:0] raw;
  } dec_t;

  localparam dec_t DEC_RESET = '{cmd: CMD_UNDEF, rm: 4'd0, rn: 4'd0, rd: 4'd0,
                                 imm: 32'd0, is32: 1'b0, raw: 32'd0};

  function automatic logic is_t32_prefix(input logic [15:0] hw);
    return (hw[15:11] == 5'b11101) || (hw[15:11] == 5'b11110) || (hw[15:11] == 5'b11111);
  endfunction

  // hw1 only matters for a 32-bit prefix; everything else decodes from hw0 alone.
  function automatic dec_t decode(input logic [15:0] hw0, input logic [15:0] hw1);
    dec_t d;
    d     = DEC_RESET;
    d.raw = {16'h0000, hw0};
    if (is_t32_prefix(hw0)) begin
      d.cmd  = CMD_T32;
      d.is32 = 1'b1;
      d.raw  = {hw0, hw1};
    end else if (hw0[15:14] == 2'b00) begin
      case (hw0[13:11])
        3'b000, 3'b001, 3'b010: begin
          d.cmd = {4'd0, hw0[13:11]};
          d.imm = {27'd0, hw0[10:6]};
          // LSR/ASR encode a shift of 32 as imm5 = 0.
          if (hw0[13:11] != 3'b000 && hw0[10:6] == 5'd0) d.imm = 32'd32;
          d.rm  = {1'b0, hw0[5:3]};
          d.rd  = {1'b0, hw0[2:0]};
        end
        3'b011: begin
          d.rn = {1'b0, hw0[5:3]};
          d.rd = {1'b0, hw0[2:0]};
          if (!hw0[10]) begin
            d.cmd = hw0[9] ? CMD_SUB_REG : CMD_ADD_REG;
            d.rm  = {1'b0, hw0[8:6]};
          end else begin
            d.cmd = hw0[9] ? CMD_SUB_IMM3 : CMD_ADD_IMM3;
            d.imm = {29'd0, hw0[8:6]};
          end
        end
        3'b100: begin
          d.cmd = CMD_MOV_IMM;
          d.rd  = {1'b0, hw0[10:8]};
          d.imm = {24'd0, hw0[7:0]};
        end
        3'b101: begin
          d.cmd = CMD_CMP_IMM;
          d.rn  = {1'b0, hw0[10:8]};
          d.imm = {24'd0, hw0[7:0]};
        end
        default: begin
          d.cmd = hw0[11] ? CMD_SUB_IMM8 : CMD_ADD_IMM8;
          d.rd  = {1'b0, hw0[10:8]};
          d.rn  = {1'b0, hw0[10:8]};
          d.imm = {24'd0, hw0[7:0]};
        end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/hw_queue.sv
// rtl/hw_queue.sv - halfword FIFO with single push, pop of 0/1/2 and two-entry peek
module hw_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic [1:0]    pop,
  output logic [W-1:0]  head,
  output logic [W-1:0]  head_next,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end

  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/thumb_decode_stage.sv
// rtl/thumb_decode_stage.sv - registered Thumb decode stage between fetch and execute
module thumb_decode_stage
  import thumb_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int CMD_W  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             hw_valid,
  input  logic [15:0]      hw_data,
  output logic             hw_ready,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [CMD_W-1:0] dec_cmd,
  output logic [3:0]       dec_rm,
  output logic [3:0]       dec_rn,
  output logic [3:0]       dec_rd,
  output logic [31:0]      dec_imm,
  output logic             dec_is32,
  output logic [31:0]      dec_raw
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [CW-1:0] count;
  logic [15:0]   head;
  logic [15:0]   head_next;
  logic [1:0]    pop_n;
  logic          push;
  logic          head_prefix;
  logic          decode_ok;
  logic          load;
  dec_t          dec_d;
  dec_t          dec_q;

  hw_queue #(.DEPTH(QDEPTH), .W(16)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (hw_data),
    .pop       (pop_n),
    .head      (head),
    .head_next (head_next),
    .count     (count)
  );

  // Space is judged on the current count only; a same-edge pop does not admit a push.
  assign hw_ready    = count < CW'(QDEPTH);
  assign push        = hw_valid && hw_ready;
  assign head_prefix = is_t32_prefix(head);
  assign decode_ok   = (count != '0) && (!head_prefix || count >= CW'(2));
  assign load        = decode_ok && (!dec_valid || dec_ready);
  assign pop_n       = load ? (head_prefix ? 2'd2 : 2'd1) : 2'd0;
  assign dec_d       = decode(head, head_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid <= 1'b0;
      dec_q     <= DEC_RESET;
    end else if (flush) begin
      dec_valid <= 1'b0;
    end else if (load) begin
      dec_valid <= 1'b1;
      dec_q     <= dec_d;
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

  assign dec_cmd  = CMD_W'(dec_q.cmd);
  assign dec_rm   = dec_q.rm;
  assign dec_rn   = dec_q.rn;
  assign dec_rd   = dec_q.rd;
  assign dec_imm  = dec_q.imm;
  assign dec_is32 = dec_q.is32;
  assign dec_raw  = dec_q.raw;

endmodule

// File: tb/tb_thumb_decode_stage.sv
// tb/tb_thumb_decode_stage.sv - directed self-checking bench for thumb_decode_stage
module tb_thumb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        hw_valid;
  logic [15:0] hw_data;
  logic        hw_ready;
  logic        dec_valid;
  logic        dec_ready;
  logic [6:0]  dec_cmd;
  logic [3:0]  dec_rm;
  logic [3:0]  dec_rn;
  logic [3:0]  dec_rd;
  logic [31:0] dec_imm;
  logic        dec_is32;
  logic [31:0] dec_raw;

  int total = 0;
  int bad   = 0;

  thumb_decode_stage #(.QDEPTH(4), .CMD_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .hw_valid  (hw_valid),
    .hw_data   (hw_data),
    .hw_ready  (hw_ready),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_cmd   (dec_cmd),
    .dec_rm    (dec_rm),
    .dec_rn    (dec_rn),
    .dec_rd    (dec_rd),
    .dec_imm   (dec_imm),
    .dec_is32  (dec_is32),
    .dec_raw   (dec_raw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; hw_valid = 1'b0; hw_data = 16'h0; dec_ready = 1'b1;
    repeat (3) step();
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", dec_valid); end
    total++; if (dec_cmd !== 7'd127) begin bad++; $display("FAIL reset_cmd got=%0d exp=127", dec_cmd); end
    total++; if (hw_ready !== 1'b1) begin bad++; $display("FAIL reset_hw_ready got=%0d exp=1", hw_ready); end
    total++; if ({dec_rm, dec_rn, dec_rd, dec_imm, dec_is32, dec_raw} !== 77'd0) begin
      bad++; $display("FAIL reset_fields got=%h exp=0", {dec_rm, dec_rn, dec_rd, dec_imm, dec_is32, dec_raw});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_mov();
    hw_valid = 1'b1; hw_data = 16'h2105;
    step();
    hw_valid = 1'b0;
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL mov_latency got=%0d exp=0", dec_valid); end
    step();
    total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL mov_valid got=%0d exp=1", dec_valid); end
    total++; if ({dec_cmd, dec_rm, dec_rn, dec_rd, dec_imm} !== {7'd7, 4'd0, 4'd0, 4'd1, 32'd5}) begin
      bad++; $display("FAIL mov_fields got cmd=%0d rm=%0d rn=%0d rd=%0d imm=%0d exp cmd=7 rm=0 rn=0 rd=1 imm=5",
                      dec_cmd, dec_rm, dec_rn, dec_rd, dec_imm);
    end
    total++; if ({dec_is32, dec_raw} !== {1'b0, 32'h0000_2105}) begin
      bad++; $display("FAIL mov_raw got is32=%0d raw=%h exp is32=0 raw=00002105", dec_is32, dec_raw);
    end
    step();
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL mov_drain got=%0d exp=0", dec_valid); end
  endtask

  task automatic test_back_to_back();
    hw_valid = 1'b1; hw_data = 16'h180A;
    step();
    hw_data = 16'h0808;
    step();
    hw_valid = 1'b0;
    total++; if ({dec_valid, dec_cmd, dec_rm, dec_rn, dec_rd, dec_imm} !== {1'b1, 7'd3, 4'd0, 4'd1, 4'd2, 32'd0}) begin
      bad++; $display("FAIL add_reg got v=%0d cmd=%0d rm=%0d rn=%0d rd=%0d imm=%0d exp v=1 cmd=3 rm=0 rn=1 rd=2 imm=0",
                      dec_valid, dec_cmd, dec_rm, dec_rn, dec_rd, dec_imm);
    end
    step();
    total++; if ({dec_valid, dec_cmd, dec_rm, dec_rn, dec_rd, dec_imm} !== {1'b1, 7'd1, 4'd1, 4'd0, 4'd0, 32'd32}) begin
      bad++; $display("FAIL lsr_imm32 got v=%0d cmd=%0d rm=%0d rn=%0d rd=%0d imm=%0d exp v=1 cmd=1 rm=1 rn=0 rd=0 imm=32",
                      dec_valid, dec_cmd, dec_rm, dec_rn, dec_rd, dec_imm);
    end
    step();
  endtask

  task automatic test_t32();
    hw_valid = 1'b1; hw_data = 16'hF000;
    step();
    hw_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL t32_wait%0d got=%0d exp=0", i, dec_valid); end
      step();
    end
    hw_valid = 1'b1; hw_data = 16'hF800;
    step();
    hw_valid = 1'b0;
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL t32_early got=%0d exp=0", dec_valid); end
    step();
    total++; if ({dec_valid, dec_cmd, dec_is32, dec_raw} !== {1'b1, 7'd126, 1'b1, 32'hF000_F800}) begin
      bad++; $display("FAIL t32_out got v=%0d cmd=%0d is32=%0d raw=%h exp v=1 cmd=126 is32=1 raw=f000f800",
                      dec_valid, dec_cmd, dec_is32, dec_raw);
    end
    total++; if ({dec_rm, dec_rn, dec_rd, dec_imm} !== 44'd0) begin
      bad++; $display("FAIL t32_fields got=%h exp=0", {dec_rm, dec_rn, dec_rd, dec_imm});
    end
    step();
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL t32_single got=%0d exp=0", dec_valid); end
  endtask

  task automatic test_stall();
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (hw_ready !== 1'b1) begin bad++; $display("FAIL stall_ready%0d got=%0d exp=1", i, hw_ready); end
      hw_valid = 1'b1; hw_data = 16'h2100 | 16'(i);
      step();
    end
    hw_data = 16'h2105;
    total++; if (hw_ready !== 1'b0) begin bad++; $display("FAIL stall_full got=%0d exp=0", hw_ready); end
    step();
    step();
    hw_valid = 1'b0;
    total++; if (hw_ready !== 1'b0) begin bad++; $display("FAIL stall_full_hold got=%0d exp=0", hw_ready); end
    total++; if ({dec_valid, dec_cmd, dec_imm, dec_raw} !== {1'b1, 7'd7, 32'd0, 32'h0000_2100}) begin
      bad++; $display("FAIL stall_hold got v=%0d cmd=%0d imm=%0d raw=%h exp v=1 cmd=7 imm=0 raw=00002100",
                      dec_valid, dec_cmd, dec_imm, dec_raw);
    end
    dec_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++; if ({dec_valid, dec_cmd, dec_rd, dec_imm} !== {1'b1, 7'd7, 4'd1, 32'(k)}) begin
        bad++; $display("FAIL stall_drain%0d got v=%0d cmd=%0d rd=%0d imm=%0d exp v=1 cmd=7 rd=1 imm=%0d",
                        k, dec_valid, dec_cmd, dec_rd, dec_imm, k);
      end
      step();
    end
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL stall_extra got=%0d exp=0", dec_valid); end
  endtask

  task automatic test_flush();
    hw_valid = 1'b1; hw_data = 16'hF000;
    step();
    flush = 1'b1; hw_data = 16'hF800;
    step();
    flush = 1'b0; hw_valid = 1'b0;
    total++; if ({dec_valid, hw_ready} !== 2'b01) begin
      bad++; $display("FAIL flush_state got v=%0d rdy=%0d exp v=0 rdy=1", dec_valid, hw_ready);
    end
    hw_valid = 1'b1; hw_data = 16'h2105;
    step();
    hw_valid = 1'b0;
    step();
    total++; if ({dec_valid, dec_cmd, dec_is32, dec_raw} !== {1'b1, 7'd7, 1'b0, 32'h0000_2105}) begin
      bad++; $display("FAIL flush_mov got v=%0d cmd=%0d is32=%0d raw=%h exp v=1 cmd=7 is32=0 raw=00002105",
                      dec_valid, dec_cmd, dec_is32, dec_raw);
    end
    dec_ready = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0d exp=0", dec_valid); end
    dec_ready = 1'b1;
    step();
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%0d exp=0", dec_valid); end
  endtask

  task automatic test_mixed();
    logic [15:0] hw_tab [5];
    logic [54:0] exp_tab [5];
    hw_tab[0] = 16'hBF00; exp_tab[0] = {7'd127, 4'd0, 4'd0, 4'd0, 32'd0,  4'd0};
    hw_tab[1] = 16'h1CCB; exp_tab[1] = {7'd5,   4'd0, 4'd1, 4'd3, 32'd3,  4'd0};
    hw_tab[2] = 16'h3A10; exp_tab[2] = {7'd10,  4'd0, 4'd2, 4'd2, 32'd16, 4'd0};
    hw_tab[3] = 16'h1000; exp_tab[3] = {7'd2,   4'd0, 4'd0, 4'd0, 32'd32, 4'd0};
    hw_tab[4] = 16'h0000; exp_tab[4] = {7'd0,   4'd0, 4'd0, 4'd0, 32'd0,  4'd0};
    for (int i = 0; i < 5; i++) begin
      hw_valid = 1'b1; hw_data = hw_tab[i];
      step();
      if (i > 0) begin
        total++; if ({dec_valid, dec_cmd, dec_rm, dec_rn, dec_rd, dec_imm, dec_raw} !== {1'b1, exp_tab[i-1][54:4], 16'h0, hw_tab[i-1]}) begin
          bad++; $display("FAIL mixed%0d got v=%0d cmd=%0d rm=%0d rn=%0d rd=%0d imm=%0d raw=%h exp=%h raw=%h",
                          i - 1, dec_valid, dec_cmd, dec_rm, dec_rn, dec_rd, dec_imm, dec_raw, exp_tab[i-1][54:4], hw_tab[i-1]);
        end
      end
    end
    hw_valid = 1'b0;
    step();
    total++; if ({dec_valid, dec_cmd, dec_imm, dec_raw} !== {1'b1, 7'd0, 32'd0, 32'h0}) begin
      bad++; $display("FAIL mixed4 got v=%0d cmd=%0d imm=%0d raw=%h exp v=1 cmd=0 imm=0 raw=0", dec_valid, dec_cmd, dec_imm, dec_raw);
    end
    step();
  endtask

  task automatic test_async_reset();
    dec_ready = 1'b0;
    hw_valid = 1'b1; hw_data = 16'h2101;
    step();
    hw_data = 16'h2102;
    step();
    #2 rst_n = 1'b0;
    #1;
    total++; if ({dec_valid, hw_ready, dec_cmd} !== {1'b0, 1'b1, 7'd127}) begin
      bad++; $display("FAIL async_reset got v=%0d rdy=%0d cmd=%0d exp v=0 rdy=1 cmd=127", dec_valid, hw_ready, dec_cmd);
    end
    hw_valid = 1'b0;
    step();
    rst_n = 1'b1; dec_ready = 1'b1;
    hw_valid = 1'b1; hw_data = 16'h2106;
    step();
    hw_valid = 1'b0;
    step();
    total++; if ({dec_valid, dec_cmd, dec_imm} !== {1'b1, 7'd7, 32'd6}) begin
      bad++; $display("FAIL post_reset got v=%0d cmd=%0d imm=%0d exp v=1 cmd=7 imm=6", dec_valid, dec_cmd, dec_imm);
    end
    step();
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL post_reset_drain got=%0d exp=0", dec_valid); end
  endtask

  initial begin
    test_reset();
    test_first_mov();
    test_back_to_back();
    test_t32();
    test_stall();
    test_flush();
    test_mixed();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
